// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data port share one memory bus.
// Ties alternate between masters; a stuck bus ends in a sticky error state cleared only by reset.
module mem_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        hold,
    output logic        timeout_err
);

    localparam int CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_grant_d;
    logic [CW-1:0] wait_cnt;
    logic          d_pending;
    logic          any_req;
    logic          pick_d;
    logic          in_grant;
    logic          wait_expire;

    assign d_pending = d_re | d_we;
    assign any_req   = i_req | d_pending;
    assign in_grant  = (state == GRANT_I) || (state == GRANT_D);

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        pick_d = 1'b0;
        if (d_pending && !i_req) begin
            pick_d = 1'b1;
        end else if (d_pending && i_req) begin
            pick_d = !last_grant_d;
        end
    end

    // A ready in the final allowed cycle beats the timeout.
    assign wait_expire = in_grant && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_next = RESP;
                end else if (wait_expire) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= 4'hF;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        last_grant_d <= (state == GRANT_D);
                        if (state == GRANT_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_ack <= 1'b1;
                            // Writes (including re+we together) leave load data untouched.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else if (wait_expire) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hold = (any_req & ~(i_ack | d_ack)) | (state == ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, tie alternation, slow store, reset mid-op,
// combined strobes, and timeout on a second instance with a short MAX_WAIT.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_t;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_re;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_ready_t;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_req, mem_we, hold, timeout_err;
    logic [3:0]  mem_be;

    logic [31:0] i_rdata_t, d_rdata_t, mem_addr_t, mem_wdata_t;
    logic        i_ack_t, d_ack_t, mem_req_t, mem_we_t, hold_t, timeout_err_t;
    logic [3:0]  mem_be_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_i_rdata;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hold(hold), .timeout_err(timeout_err)
    );

    mem_arbiter #(.MAX_WAIT(4)) dut_t (
        .clk(clk), .rst(rst_t),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_t), .i_ack(i_ack_t),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata_t), .d_ack(d_ack_t),
        .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
        .mem_be(mem_be_t), .mem_rdata(mem_rdata), .mem_ready(mem_ready_t),
        .hold(hold_t), .timeout_err(timeout_err_t)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0; d_re = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        mem_ready = 1'b0; mem_ready_t = 1'b0;
    endtask

    initial begin
        int waited;
        clear_inputs();
        rst = 1'b1;
        rst_t = 1'b1;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_acks", 32'({i_ack, d_ack}), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        check("rst_hold", 32'(hold), 0);
        rst = 1'b0;

        // Fetch with single-cycle memory
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        check("fetch_hold_req", 32'(hold), 1);
        tick();
        check("fetch_mem_req", 32'(mem_req), 1);
        check("fetch_mem_addr", mem_addr, 32'h100);
        check("fetch_mem_we", 32'(mem_we), 0);
        check("fetch_mem_be", 32'(mem_be), 32'hF);
        check("fetch_no_ack_yet", 32'(i_ack), 0);
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        check("fetch_i_ack", 32'(i_ack), 1);
        check("fetch_d_ack", 32'(d_ack), 0);
        check("fetch_i_rdata", i_rdata, 32'h0050_0093);
        check("fetch_mem_req_drop", 32'(mem_req), 0);
        check("fetch_hold_ack", 32'(hold), 0);
        i_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        tick();
        check("fetch_ack_width", 32'(i_ack), 0);
        check("fetch_i_rdata_hold", i_rdata, 32'h0050_0093);

        // Tie: both masters held from reset, D wins first and they alternate
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h100; d_re = 1'b1; d_addr = 32'h300;
        tick();
        rst = 1'b0;
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h100);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_addr;
            waited = 0;
            while (!mem_req && waited < 10) begin
                tick();
                waited++;
            end
            check("tie_grant_wait", 32'(mem_req), 1);
            exp_addr = exp_q.pop_front();
            check("tie_grant_order", mem_addr, exp_addr);
            mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(k);
            tick();
            mem_ready = 1'b0;
            check("tie_d_ack", 32'(d_ack), 32'(exp_addr == 32'h300));
            check("tie_i_ack", 32'(i_ack), 32'(exp_addr == 32'h100));
            tick();
            check("tie_ack_width", 32'({i_ack, d_ack}), 0);
        end
        exp_d_rdata = 32'hA2;
        exp_i_rdata = 32'hA3;
        check("tie_d_rdata", d_rdata, exp_d_rdata);
        check("tie_i_rdata", i_rdata, exp_i_rdata);
        clear_inputs();
        tick();
        tick();

        // Store with memory stalled for five cycles
        d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("store_mem_req", 32'(mem_req), 1);
            check("store_mem_we", 32'(mem_we), 1);
            check("store_mem_addr", mem_addr, 32'h2004);
            check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("store_mem_be", 32'(mem_be), 32'h3);
            check("store_hold", 32'(hold), 1);
            check("store_no_ack", 32'(d_ack), 0);
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ready = 1'b0;
        check("store_d_ack", 32'(d_ack), 1);
        check("store_hold_ack", 32'(hold), 0);
        check("store_d_rdata_kept", d_rdata, exp_d_rdata);
        d_we = 1'b0;
        tick();

        // Read and write strobes together: a write, load data untouched
        d_re = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; d_be = 4'hF;
        tick();
        check("both_mem_we", 32'(mem_we), 1);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ready = 1'b0;
        check("both_d_ack", 32'(d_ack), 1);
        check("both_d_rdata_kept", d_rdata, exp_d_rdata);
        d_re = 1'b0; d_we = 1'b0;
        tick();

        // Reset lands together with mem_ready during a data read
        d_re = 1'b1; d_addr = 32'h50;
        tick();
        check("rstop_granted", 32'(mem_req), 1);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h777;
        tick();
        check("rstop_no_ack", 32'({i_ack, d_ack}), 0);
        check("rstop_mem_req", 32'(mem_req), 0);
        check("rstop_mem_addr", mem_addr, 0);
        check("rstop_mem_be", 32'(mem_be), 0);
        check("rstop_rdata", i_rdata | d_rdata, 0);
        clear_inputs();
        rst = 1'b0;
        tick();
        check("rstop_no_late_ack", 32'(d_ack), 0);

        // Short-timeout instance: ready in the last allowed cycle still completes
        rst_t = 1'b0;
        i_req = 1'b1; i_addr = 32'h80;
        tick();
        check("edge_granted", 32'(mem_req_t), 1);
        tick();
        tick();
        tick();
        mem_ready_t = 1'b1; mem_rdata = 32'hCAFE;
        tick();
        mem_ready_t = 1'b0;
        i_req = 1'b0;
        check("edge_i_ack", 32'(i_ack_t), 1);
        check("edge_no_error", 32'(timeout_err_t), 0);
        check("edge_i_rdata", i_rdata_t, 32'hCAFE);
        tick();

        // No ready at all: error after four wait cycles
        d_we = 1'b1; d_addr = 32'h90; d_wdata = 32'h1; d_be = 4'hF;
        tick();
        tick();
        tick();
        tick();
        check("to_still_waiting", 32'(mem_req_t), 1);
        check("to_not_yet", 32'(timeout_err_t), 0);
        tick();
        check("to_mem_req", 32'(mem_req_t), 0);
        check("to_flag", 32'(timeout_err_t), 1);
        check("to_acks", 32'({i_ack_t, d_ack_t}), 0);
        d_we = 1'b0;
        #1;
        check("to_hold_forced", 32'(hold_t), 1);
        i_req = 1'b1; mem_ready_t = 1'b1;
        tick();
        tick();
        tick();
        check("to_ignored_req", 32'(mem_req_t), 0);
        check("to_ignored_ack", 32'({i_ack_t, d_ack_t}), 0);
        check("to_sticky", 32'(timeout_err_t), 1);
        rst_t = 1'b1; mem_ready_t = 1'b0;
        tick();
        check("to_rst_clears", 32'(timeout_err_t), 0);
        rst_t = 1'b0;
        tick();
        check("to_rst_regrant", 32'(mem_req_t), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 255, meaning the maximum number of cycles mem_req stays high without mem_ready before a timeout.
REQ-002 The block SHALL have the following ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  instruction-fetch read request.
- i_addr  input  32  fetch address.
- i_rdata  output  32  fetched word, registered.
- i_ack  output  1  one-cycle fetch completion pulse.
- d_re  input  1  data read request.
- d_we  input  1  data write request.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_be  input  4  byte enables.
- d_rdata  output  32  load data, registered.
- d_ack  output  1  one-cycle data completion pulse.
- mem_req  output  1  memory transaction valid.
- mem_we  output  1  memory write strobe.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_be  output  4  memory byte enables.
- mem_rdata  input  32  memory read data; valid with mem_ready.
- mem_ready  input  1  memory completion.
- hold  output  1  stall to the control unit.
- timeout_err  output  1  sticky bus-timeout flag.

Function
REQ-003 The block SHALL implement the states IDLE, GRANT_I, GRANT_D, RESP and ERR.
REQ-004 In IDLE, the block SHALL grant as follows:
- Only i_req pending -> GRANT_I.
- Only d_re or d_we pending -> GRANT_D.
- Both pending -> the requester not granted last (last_grant register, reset value = I, so D wins the first tie).
REQ-005 On the grant edge, the block SHALL register mem_addr, mem_wdata, mem_be and mem_we from the winner (I: mem_we=0, mem_be=4'hF, mem_wdata=0); mem_req SHALL go high the cycle after the request is sampled in IDLE.
REQ-006 In GRANT_*, the registered mem_* outputs SHALL stay stable and mem_req SHALL stay high until mem_ready is sampled high.
REQ-007 On the mem_ready edge, the block SHALL:
- capture mem_rdata into i_rdata or d_rdata (reads only);
- drop mem_req;
- enter RESP;
- update last_grant.
REQ-008 In RESP, exactly one of i_ack/d_ack SHALL be high for exactly one cycle, after which the state SHALL return to IDLE; requests are not sampled in RESP.
REQ-009 Minimum latency SHALL be: request at cycle N, mem_ready at N+1 -> ack at N+2, next grant sampled at N+3.
REQ-010 When d_re and d_we are both high, the block SHALL perform a write (mem_we=1), pulse d_ack and leave d_rdata unchanged.
REQ-011 i_rdata and d_rdata SHALL hold their values until the next completed read on the same port.
REQ-012 hold SHALL equal (i_req | d_re | d_we) & ~(i_ack | d_ack), combinationally, and SHALL be forced to 1 in ERR.
REQ-013 An 8-bit-minimum wait counter SHALL:
- clear on grant;
- increment each GRANT_* cycle without mem_ready;
- on reaching MAX_WAIT, move the state to ERR.
REQ-014 In ERR, mem_req and both acks SHALL be 0 and timeout_err SHALL be 1; ERR SHALL be exited only by rst.
REQ-015 A mem_ready arriving in the same cycle the counter reaches MAX_WAIT SHALL complete normally, with no error.
REQ-016 mem_ready sampled while not in GRANT_* SHALL be ignored.

Reset
REQ-017 On rst=1 at a rising edge, the block SHALL reset as follows:
- state=IDLE;
- last_grant=I;
- wait counter=0;
- mem_req, mem_we, i_ack, d_ack, timeout_err = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0;
- mem_be=0.
REQ-018 Reset asserted mid-transaction SHALL drop mem_req on the next edge and discard the transaction without generating any ack.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Fetch: i_req=1, i_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0x00500093 -> i_ack pulse 2 cycles after request; i_rdata=0x00500093; mem_we=0.
- Tie: i_req and d_re both held high from reset -> grant order D, I, D, I; each ack is exactly one cycle wide.
- Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ready delayed 5 cycles -> mem_* outputs stable across all 5 wait cycles; hold=1 until d_ack.
- Timeout: MAX_WAIT=4, mem_ready never asserted -> ERR after 4 wait cycles; mem_req=0; timeout_err=1; hold=1; new requests ignored until rst.
- Reset mid-op: rst asserted in GRANT_D with mem_ready arriving the same cycle -> no ack; all outputs at REQ-017 values next cycle.
- Both strobes: d_re=d_we=1 -> mem_we=1; d_rdata unchanged after d_ack.
